ws2812_frame_ctrl: RTL

//  Frame sequencer sitting directly upstream of the RZ LED encoder. Holds one frame of

---
 rtl/ws2812_frame_ctrl_if.sv | 38 +++
 rtl/ws2812_frame_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl_if.sv
// rtl/ws2812_frame_ctrl_if.sv - pixel-buffer write, frame control and encoder handshake bundle
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic [23:0]       RGB;
    logic              tx_en;
    logic              tx_done;

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  start,
        input  tx_done,
        output busy,
        output frame_done,
        output RGB,
        output tx_en
    );

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output start,
        output tx_done,
        input  busy,
        input  frame_done,
        input  RGB,
        input  tx_en
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 frame sequencer: pixel buffer, GRB streaming to encoder, latch hold
module ws2812_frame_ctrl #(
    parameter int LED_NUM      = 64,
    parameter int ADDR_W       = 6,
    parameter int RESET_CYCLES = 15000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ws2812_frame_ctrl_if.slave    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_NUM - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RESET_CYCLES - 1);

    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    logic [23:0]       mem [LED_NUM];
    logic [23:0]       rd_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_range;
    logic              wr_ok;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_en_q, tx_en_d;
    logic [23:0]       rgb_q, rgb_d;

    generate
        if (LED_NUM >= (1 << ADDR_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = (bus.wr_addr < ADDR_W'(LED_NUM));
        end
    endgenerate

    assign wr_ok = bus.wr_en && in_range;

    // Prefetch the next pixel while the current one is on the wire.
    always_comb begin
        rd_addr = '0;
        if (state_q == S_SEND) begin
            rd_addr = idx_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Write-first read so a pixel updated one cycle before its tx_done is still sent.
    always_ff @(posedge clk) begin
        if (wr_ok && (bus.wr_addr == rd_addr)) begin
            rd_q <= bus.wr_data;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_en_d = tx_en_q;
        rgb_d   = rgb_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                rgb_d   = to_grb(rd_q);
                tx_en_d = 1'b1;
            end
            S_SEND: begin
                if (bus.tx_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + ADDR_W'(1);
                        rgb_d = to_grb(rd_q);
                    end else begin
                        tx_en_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_en_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_en_q <= tx_en_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.RGB        = rgb_q;

endmodule
